// File: rtl/fnd_sender_pkg.sv
// Shared types and ASCII constants for the FND time-frame sender.
// Frame layout: "HH:MM:SS.CC" with an optional CR LF tail.
package fnd_sender_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACK,
    WAIT_TX,
    DONE
  } state_t;

  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] DOT   = 8'h2E;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] QMARK = 8'h3F;
  localparam logic [7:0] ZERO  = 8'h30;

  localparam int FRAME_LEN_CRLF   = 13;
  localparam int FRAME_LEN_NOCRLF = 11;

endpackage

// File: rtl/sender_tick_gen.sv
// Periodic auto-report tick; the count restarts from zero
// whenever auto_en drops.
module sender_tick_gen #(
  parameter int AUTO_PERIOD_CLKS = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic auto_en,
  output logic auto_tick
);

  localparam int CW = (AUTO_PERIOD_CLKS > 2) ?
                      $clog2(AUTO_PERIOD_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(AUTO_PERIOD_CLKS - 1);

  logic [CW-1:0] cnt;

  assign auto_tick = auto_en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!auto_en || auto_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fnd_time_sender.sv
// Captures the BCD time snapshot and streams it as an ASCII
// frame to a byte UART over a start/busy handshake.
module fnd_time_sender
  import fnd_sender_pkg::*;
#(
  parameter int AUTO_PERIOD_CLKS = 100_000_000,
  parameter int ACK_TIMEOUT      = 16,
  parameter bit CRLF_EN          = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_req,
  input  logic        auto_en,
  input  logic [31:0] digits_in,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done,
  output logic        dropped
);

  localparam int FRAME_LEN = CRLF_EN ? FRAME_LEN_CRLF
                                     : FRAME_LEN_NOCRLF;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic [3:0]    idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic [AW-1:0] ack_q, ack_d;
  logic          tx_start_d;
  logic [7:0]    tx_data_d;
  logic          dropped_d;
  logic          auto_tick;
  logic          req;
  logic [7:0]    byte_sel;

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (ZERO | {4'h0, n}) : QMARK;
  endfunction

  sender_tick_gen #(
    .AUTO_PERIOD_CLKS(AUTO_PERIOD_CLKS)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .auto_en  (auto_en),
    .auto_tick(auto_tick)
  );

  assign req  = send_req | auto_tick;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_comb begin
    byte_sel = 8'h00;
    unique case (idx_q)
      4'd0:    byte_sel = to_ascii(snap_q[31:28]);
      4'd1:    byte_sel = to_ascii(snap_q[27:24]);
      4'd2:    byte_sel = COLON;
      4'd3:    byte_sel = to_ascii(snap_q[23:20]);
      4'd4:    byte_sel = to_ascii(snap_q[19:16]);
      4'd5:    byte_sel = COLON;
      4'd6:    byte_sel = to_ascii(snap_q[15:12]);
      4'd7:    byte_sel = to_ascii(snap_q[11:8]);
      4'd8:    byte_sel = DOT;
      4'd9:    byte_sel = to_ascii(snap_q[7:4]);
      4'd10:   byte_sel = to_ascii(snap_q[3:0]);
      4'd11:   byte_sel = CR;
      4'd12:   byte_sel = LF;
      default: byte_sel = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    ack_d      = ack_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    dropped_d  = 1'b0;

    // One request may wait behind the active frame
    if (state_q != IDLE && req) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (state_q != DONE) begin
        dropped_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (req || pending_q) begin
          state_d   = LOAD;
          pending_d = 1'b0;
        end
      end
      LOAD: begin
        snap_d  = digits_in;
        idx_d   = 4'd0;
        state_d = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_sel;
          ack_d      = '0;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy || ack_q == ACK_LAST) begin
          state_d = WAIT_TX;
        end else begin
          ack_d = ack_q + 1'b1;
        end
      end
      WAIT_TX: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SEND;
          end
        end
      end
      DONE: begin
        // A request arriving now refills the slot being consumed
        if (pending_q) begin
          state_d   = LOAD;
          pending_d = req;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      idx_q     <= 4'd0;
      snap_q    <= 32'h0;
      ack_q     <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      dropped   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      ack_q     <= ack_d;
      tx_start  <= tx_start_d;
      tx_data   <= tx_data_d;
      dropped   <= dropped_d;
    end
  end

endmodule

// File: tb/tb_fnd_time_sender.sv
// Self-checking bench for fnd_time_sender: vector table, random
// frames against a frame model, and multi-cycle corner sequences.
module tb_fnd_time_sender;

  localparam int P  = 50;
  localparam int AT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send_req = 1'b0;
  logic        auto_en = 1'b0;
  logic [31:0] digits_in = 32'h0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic        dropped;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int uart_len = 10;
  int bcnt = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  logic [7:0] bq[$];
  int         tq[$];

  int s, s2, d0, dr0, req_edge, e0, n;
  logic [31:0] rd;

  typedef struct {
    logic [31:0] digits;
    bit          scramble;
    logic [7:0]  exp [13];
  } vec_t;
  vec_t vt [3];

  fnd_time_sender #(
    .AUTO_PERIOD_CLKS(P),
    .ACK_TIMEOUT     (AT),
    .CRLF_EN         (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .send_req (send_req),
    .auto_en  (auto_en),
    .digits_in(digits_in),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // UART responder: busy for uart_len cycles per byte, 0 = never
  always @(negedge clk) begin
    if (rst || uart_len == 0) begin
      tx_busy = 1'b0;
      bcnt = 0;
    end else if (tx_start) begin
      tx_busy = 1'b1;
      bcnt = uart_len;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) tx_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        bq.push_back(tx_data);
        tq.push_back(cyc);
      end
      if (done) done_cnt++;
      if (dropped) drop_cnt++;
    end
  end

  function automatic logic [7:0] ref_byte(logic [31:0] d, int i);
    int k;
    int v;
    case (i)
      2, 5: return 8'h3A;
      8:    return 8'h2E;
      11:   return 8'h0D;
      12:   return 8'h0A;
      default: ;
    endcase
    k = i - i / 3;
    v = int'((d >> (28 - 4 * k)) & 32'hF);
    return (v < 10) ? 8'(48 + v) : 8'h3F;
  endfunction

  function automatic int qb(int i);
    return (i < bq.size()) ? int'(bq[i]) : -1;
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    @(posedge clk);
    #1 send_req = 1'b1;
    req_edge = cyc + 1;
    @(posedge clk);
    #1 send_req = 1'b0;
  endtask

  task automatic wait_done(string name, int target, int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(name, (done_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic check_frame(string name, int start, logic [31:0] d);
    for (int i = 0; i < 13; i++)
      chk($sformatf("%s[%0d]", name, i), qb(start + i),
          int'(ref_byte(d, i)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0].digits = 32'h1234_5678;
    vt[0].scramble = 1'b0;
    vt[0].exp = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35,
                  8'h36, 8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};
    vt[1].digits = 32'hA9F0_0000;
    vt[1].scramble = 1'b1;
    vt[1].exp = '{8'h3F, 8'h39, 8'h3A, 8'h3F, 8'h30, 8'h3A, 8'h30,
                  8'h30, 8'h2E, 8'h30, 8'h30, 8'h0D, 8'h0A};
    vt[2].digits = 32'h2359_5999;
    vt[2].scramble = 1'b0;
    vt[2].exp = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35,
                  8'h39, 8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dropped", int'(dropped), 0);
    rst = 1'b0;
    tick(2);

    // vector table, slow UART
    uart_len = 10;
    for (int v = 0; v < 3; v++) begin
      s = bq.size();
      d0 = done_cnt;
      digits_in = vt[v].digits;
      pulse_req();
      if (vt[v].scramble) begin
        tick(2);
        digits_in = 32'h0;
      end
      wait_done($sformatf("vec%0d_done_wait", v), d0 + 1, 600);
      tick(3);
      chk($sformatf("vec%0d_len", v), bq.size() - s, 13);
      for (int i = 0; i < 13; i++)
        chk($sformatf("vec%0d_b%0d", v, i), qb(s + i),
            int'(vt[v].exp[i]));
      chk($sformatf("vec%0d_done", v), done_cnt - d0, 1);
      chk($sformatf("vec%0d_busy", v), int'(busy), 0);
      if (v == 0)
        chk("latency", (s < tq.size()) ? tq[s] - req_edge : -1, 2);
    end

    // random digits and UART speeds against the frame model
    for (int r = 0; r < 6; r++) begin
      rd = $urandom;
      uart_len = $urandom_range(1, 12);
      s = bq.size();
      d0 = done_cnt;
      digits_in = rd;
      pulse_req();
      wait_done($sformatf("rnd%0d_done_wait", r), d0 + 1, 800);
      tick(3);
      chk($sformatf("rnd%0d_len", r), bq.size() - s, 13);
      check_frame($sformatf("rnd%0d", r), s, rd);
    end

    // queueing: 3 requests in one frame -> 2 frames, 1 drop
    uart_len = 10;
    digits_in = 32'h0102_0304;
    s = bq.size();
    d0 = done_cnt;
    dr0 = drop_cnt;
    pulse_req();
    tick(20);
    pulse_req();
    tick(20);
    pulse_req();
    wait_done("q_done_wait", d0 + 2, 1200);
    tick(200);
    chk("q_len", bq.size() - s, 26);
    chk("q_done", done_cnt - d0, 2);
    chk("q_dropped", drop_cnt - dr0, 1);
    check_frame("q_f0", s, 32'h0102_0304);
    check_frame("q_f1", s + 13, 32'h0102_0304);

    // auto report with a manual request on the first tick
    uart_len = 1;
    digits_in = 32'h1959_3012;
    s = bq.size();
    d0 = done_cnt;
    dr0 = drop_cnt;
    @(posedge clk);
    #1 auto_en = 1'b1;
    e0 = cyc;
    tick(49);
    send_req = 1'b1;
    tick(1);
    send_req = 1'b0;
    tick(140);
    auto_en = 1'b0;
    tick(60);
    chk("auto_len", bq.size() - s, 39);
    chk("auto_done", done_cnt - d0, 3);
    chk("auto_dropped", drop_cnt - dr0, 0);
    chk("auto_first", (s < tq.size()) ? tq[s] - e0 : -1, P + 2);
    chk("auto_second",
        (s + 13 < tq.size()) ? tq[s + 13] - e0 : -1, 2 * P + 2);
    check_frame("auto_f0", s, 32'h1959_3012);
    check_frame("auto_f2", s + 26, 32'h1959_3012);

    // handshake timeout: UART never answers
    uart_len = 0;
    digits_in = 32'h0000_0001;
    s = bq.size();
    d0 = done_cnt;
    pulse_req();
    wait_done("to_done_wait", d0 + 1, 400);
    tick(3);
    chk("to_len", bq.size() - s, 13);
    chk("to_done", done_cnt - d0, 1);
    n = (s + 1 < tq.size()) ? tq[s + 1] - tq[s] : -1;
    chk("to_gap", (n >= AT && n <= AT + 3) ? 1 : 0, 1);
    check_frame("to", s, 32'h0000_0001);

    // reset after the fourth byte, then a clean restart
    uart_len = 10;
    digits_in = 32'h0912_3456;
    s = bq.size();
    d0 = done_cnt;
    dr0 = drop_cnt;
    pulse_req();
    n = 0;
    while (bq.size() < s + 4 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("rm_reach4", (bq.size() >= s + 4) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    chk("rm_tx_start", int'(tx_start), 0);
    chk("rm_busy", int'(busy), 0);
    chk("rm_done", int'(done), 0);
    chk("rm_dropped", int'(dropped), 0);
    tick(3);
    rst = 1'b0;
    tick(5);
    chk("rm_no_done", done_cnt - d0, 0);
    digits_in = 32'h0712_3456;
    s2 = bq.size();
    pulse_req();
    wait_done("rm_done_wait", d0 + 1, 600);
    tick(3);
    chk("rm_len", bq.size() - s2, 13);
    chk("rm_first", qb(s2), 8'h30);
    check_frame("rm", s2, 32'h0712_3456);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
